// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive path: phase/symbol map,
// quarter-period offset and controller state encoding.
package qpsk_pkg;

  // Gray-coded phase map shared with the transmit modulator
  localparam logic [1:0] SYM_SIN  = 2'b00;
  localparam logic [1:0] SYM_COS  = 2'b01;
  localparam logic [1:0] SYM_NSIN = 2'b11;
  localparam logic [1:0] SYM_NCOS = 2'b10;

  // Nominal carrier period in samples and its quarter (sin -> cos shift)
  localparam int unsigned QPSK_N = 32;

  function automatic int unsigned quarter_offset(input int unsigned n);
    return n / 4;
  endfunction

  localparam int unsigned QUARTER_OFFSET = quarter_offset(QPSK_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

endpackage

// File: rtl/qpsk_ref_lut.sv
// Combinational signed sine reference, round(127*sin(2*pi*k/32)).
// Two independent read ports so the sine and cosine references can be
// fetched in the same cycle. The table is built by quadrant folding of a
// 9-entry magnitude table and therefore covers a 32-entry period.
module qpsk_ref_lut #(
  parameter int N = 32
) (
  input  logic [$clog2(N)-1:0] index_sin,
  input  logic [$clog2(N)-1:0] index_cos,
  output logic signed [7:0]    sin_ref,
  output logic signed [7:0]    cos_ref
);

  // First-quadrant magnitudes, 0..N/4 inclusive
  function automatic logic signed [7:0] mag(input logic [3:0] m);
    logic signed [7:0] v;
    case (m)
      4'd0:    v = 8'sd0;
      4'd1:    v = 8'sd25;
      4'd2:    v = 8'sd49;
      4'd3:    v = 8'sd71;
      4'd4:    v = 8'sd90;
      4'd5:    v = 8'sd106;
      4'd6:    v = 8'sd117;
      4'd7:    v = 8'sd125;
      default: v = 8'sd127;
    endcase
    return v;
  endfunction

  // Fold a full-period index onto the first quadrant and restore the sign
  function automatic logic signed [7:0] sin_val(input logic [4:0] idx);
    logic [3:0]        m;
    logic signed [7:0] v;
    m = {1'b0, idx[2:0]};
    case (idx[4:3])
      2'd0:    v = mag(m);
      2'd1:    v = mag(4'd8 - m);
      2'd2:    v = -mag(m);
      default: v = -mag(4'd8 - m);
    endcase
    return v;
  endfunction

  // Both reference ports are pure table reads
  always_comb begin
    sin_ref = sin_val(index_sin);
    cos_ref = sin_val(index_cos);
  end

endmodule

// File: rtl/qpsk_demodulator.sv
// Coherent QPSK demodulator: correlates one carrier period of ADC samples
// against local sine/cosine, decides the Gray-coded symbol, gates on
// correlation energy to find end of packet, and serialises symbols MSB first.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no packet; samples ignored until sample_valid & sync
// ACCUM  | inside a packet; accumulating I/Q for the current symbol
// DECIDE | one cycle after a full symbol; decide/gate while the next
//        | symbol's first sample may already be accumulating
module qpsk_demodulator
  import qpsk_pkg::*;
#(
  parameter int              SAMPLE_W        = 8,
  parameter int              SAMPLES_PER_SYM = QPSK_N,
  parameter int              ACC_W           = 22,
  parameter logic [ACC_W-1:0] THRESH         = 22'd40000
) (
  input  logic                clk_slow,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                sync,
  output logic [1:0]          sym_out,
  output logic                sym_valid,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                locked,
  output logic                pkt_end
);

  localparam int IW   = $clog2(SAMPLES_PER_SYM);
  localparam int PW   = 2 * SAMPLE_W;
  localparam logic [IW-1:0] K_LAST = IW'(SAMPLES_PER_SYM - 1);
  localparam logic [IW-1:0] K_QTR  = IW'(quarter_offset(SAMPLES_PER_SYM));

  state_t                   state;
  logic [IW-1:0]            k;
  logic [IW-1:0]            k_cos;
  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic signed [ACC_W-1:0]  fin_i, fin_q;
  logic                     bit_pend;
  logic                     bit_hold;

  logic signed [SAMPLE_W-1:0] s_val;
  logic signed [7:0]          sin_ref, cos_ref;
  logic signed [PW-1:0]       prod_i, prod_q;
  logic signed [ACC_W-1:0]    term_i, term_q;
  logic signed [ACC_W-1:0]    sum_i, sum_q;
  logic [ACC_W-1:0]           abs_i, abs_q, mag_max;
  logic                       gate_open;
  logic [1:0]                 dec_sym;

  // Cosine is the sine table advanced by a quarter period; the index wraps
  // naturally because the period is a power of two.
  assign k_cos = k + K_QTR;

  qpsk_ref_lut #(.N(SAMPLES_PER_SYM)) u_ref_lut (
    .index_sin (k),
    .index_cos (k_cos),
    .sin_ref   (sin_ref),
    .cos_ref   (cos_ref)
  );

  // Offset binary to two's complement is an MSB flip
  assign s_val  = {~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0]};
  assign prod_i = PW'(s_val) * PW'(sin_ref);
  assign prod_q = PW'(s_val) * PW'(cos_ref);
  assign term_i = ACC_W'(prod_i);
  assign term_q = ACC_W'(prod_q);
  assign sum_i  = acc_i + term_i;
  assign sum_q  = acc_q + term_q;

  // Decision on the latched correlations; magnitudes never reach -2^(ACC_W-1)
  assign abs_i     = fin_i[ACC_W-1] ? -fin_i : fin_i;
  assign abs_q     = fin_q[ACC_W-1] ? -fin_q : fin_q;
  assign mag_max   = (abs_i >= abs_q) ? abs_i : abs_q;
  assign gate_open = (mag_max >= THRESH);
  assign dec_sym   = (abs_i >= abs_q) ? (fin_i[ACC_W-1] ? SYM_NSIN : SYM_SIN)
                                      : (fin_q[ACC_W-1] ? SYM_NCOS : SYM_COS);

  assign locked = (state == ACCUM) || (state == DECIDE);

  // Controller, correlator accumulators and two-bit serialiser
  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      fin_i     <= '0;
      fin_q     <= '0;
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_hold  <= 1'b0;
      bit_pend  <= 1'b0;
      pkt_end   <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      bit_valid <= 1'b0;
      pkt_end   <= 1'b0;

      // Second (LSB) bit goes out the cycle after the MSB
      if (bit_pend) begin
        bit_out   <= bit_hold;
        bit_valid <= 1'b1;
        bit_pend  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sample_valid && sync) begin
            state <= ACCUM;
            k     <= IW'(1);
            acc_i <= term_i;
            acc_q <= term_q;
          end
        end

        ACCUM, DECIDE: begin
          if (state == DECIDE && !gate_open) begin
            // Energy gone: close the packet and drop any in-flight sample
            pkt_end <= 1'b1;
            state   <= IDLE;
            acc_i   <= '0;
            acc_q   <= '0;
            k       <= '0;
          end else begin
            if (state == DECIDE) begin
              sym_out   <= dec_sym;
              sym_valid <= 1'b1;
              bit_out   <= dec_sym[1];
              bit_valid <= 1'b1;
              bit_hold  <= dec_sym[0];
              bit_pend  <= 1'b1;
              state     <= ACCUM;
            end
            if (sample_valid) begin
              if (sync && k != '0) begin
                // Re-sync mid-symbol: this sample becomes sample 0
                acc_i <= term_i;
                acc_q <= term_q;
                k     <= IW'(1);
              end else if (k == K_LAST) begin
                fin_i <= sum_i;
                fin_q <= sum_q;
                acc_i <= '0;
                acc_q <= '0;
                k     <= '0;
                state <= DECIDE;
              end else begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                k     <= k + IW'(1);
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Directed bench for qpsk_demodulator with a symbol/bit scoreboard.
module tb_qpsk_demodulator;

  logic       clk_slow = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample_in = 8'd128;
  logic       sample_valid = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       bit_out;
  logic       bit_valid;
  logic       locked;
  logic       pkt_end;

  int checks = 0;
  int failures = 0;
  int pkt_seen = 0;
  int pkt_exp = 0;

  logic [1:0] exp_sym_q[$];
  logic       exp_bit_q[$];

  qpsk_demodulator dut (
    .clk_slow     (clk_slow),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sync         (sync),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .locked       (locked),
    .pkt_end      (pkt_end)
  );

  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_sin(input int k);
    return int'(127.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 32.0));
  endfunction

  // Ideal carrier sample for a given phase at sample index k
  function automatic logic [7:0] samp(input logic [1:0] sym, input int k);
    int v;
    case (sym)
      2'b00:   v = 128 + ref_sin(k);
      2'b01:   v = 128 + ref_sin((k + 8) % 32);
      2'b11:   v = 128 - ref_sin(k);
      default: v = 128 - ref_sin((k + 8) % 32);
    endcase
    return 8'(v);
  endfunction

  task automatic tick(input logic v, input logic s, input logic [7:0] val);
    sample_valid = v;
    sync         = s;
    sample_in    = val;
    @(posedge clk_slow);
    #1;
  endtask

  task automatic send_sym(input logic [1:0] sym, input logic use_sync,
                          input logic gap, input logic push);
    if (push) begin
      exp_sym_q.push_back(sym);
      exp_bit_q.push_back(sym[1]);
      exp_bit_q.push_back(sym[0]);
    end
    for (int k = 0; k < 32; k++) begin
      if (gap && k > 0) tick(1'b0, 1'b0, 8'h55);
      tick(1'b1, use_sync && (k == 0), samp(sym, k));
    end
    sample_valid = 1'b0;
    sync         = 1'b0;
  endtask

  task automatic send_mid();
    pkt_exp++;
    for (int k = 0; k < 32; k++) tick(1'b1, 1'b0, 8'd128);
    sample_valid = 1'b0;
  endtask

  // Scoreboard: every produced symbol/bit must match the next expected one
  always @(negedge clk_slow) begin
    if (sym_valid) begin
      checks++;
      assert (exp_sym_q.size() > 0) else begin
        failures++;
        $error("FAIL sym_unexpected observed=%0h expected=none", sym_out);
      end
      if (exp_sym_q.size() > 0) chk("sym_out_sb", 32'(sym_out), 32'(exp_sym_q.pop_front()));
    end
    if (bit_valid) begin
      checks++;
      assert (exp_bit_q.size() > 0) else begin
        failures++;
        $error("FAIL bit_unexpected observed=%0h expected=none", bit_out);
      end
      if (exp_bit_q.size() > 0) chk("bit_out_sb", 32'(bit_out), 32'(exp_bit_q.pop_front()));
    end
    if (pkt_end) pkt_seen++;
  end

  initial begin
    // Reset values
    rst = 1'b0;
    repeat (3) @(posedge clk_slow);
    #1;
    chk("rst_sym_out", 32'(sym_out), 0);
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_bit_out", 32'(bit_out), 0);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pkt_end", 32'(pkt_end), 0);
    rst = 1'b1;
    tick(1'b0, 1'b0, 8'd128);

    // Single +sin symbol, latency and two-bit serialisation
    send_sym(2'b00, 1'b1, 1'b0, 1'b1);
    chk("a_locked", 32'(locked), 1);
    chk("a_sym_valid_at_T", 32'(sym_valid), 0);
    tick(1'b0, 1'b0, 8'd128);
    chk("a_sym_valid", 32'(sym_valid), 1);
    chk("a_sym_out", 32'(sym_out), 32'(2'b00));
    chk("a_bit_valid_1", 32'(bit_valid), 1);
    chk("a_bit_out_1", 32'(bit_out), 0);
    tick(1'b0, 1'b0, 8'd128);
    chk("a_bit_valid_2", 32'(bit_valid), 1);
    chk("a_bit_out_2", 32'(bit_out), 0);
    chk("a_sym_valid_off", 32'(sym_valid), 0);
    tick(1'b0, 1'b0, 8'd128);
    chk("a_bit_valid_3", 32'(bit_valid), 0);

    // Four back-to-back symbols, then midscale closes the packet
    send_sym(2'b01, 1'b0, 1'b0, 1'b1);
    send_sym(2'b11, 1'b0, 1'b0, 1'b1);
    send_sym(2'b10, 1'b0, 1'b0, 1'b1);
    send_sym(2'b00, 1'b0, 1'b0, 1'b1);
    send_mid();
    tick(1'b0, 1'b0, 8'd128);
    chk("c_pkt_end", 32'(pkt_end), 1);
    chk("c_locked_fall", 32'(locked), 0);
    chk("c_no_sym", 32'(sym_valid), 0);
    tick(1'b0, 1'b0, 8'd128);
    chk("c_pkt_end_pulse", 32'(pkt_end), 0);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, samp(2'b00, i % 32));
    chk("c_idle_ignores", 32'(locked), 0);

    // +cos with sample_valid every other cycle
    send_sym(2'b01, 1'b1, 1'b1, 1'b1);
    chk("d_sym_valid_at_T", 32'(sym_valid), 0);
    tick(1'b0, 1'b0, 8'd128);
    chk("d_sym_valid", 32'(sym_valid), 1);
    chk("d_sym_out", 32'(sym_out), 32'(2'b01));
    send_mid();
    tick(1'b0, 1'b0, 8'd128);
    tick(1'b0, 1'b0, 8'd128);

    // Re-sync at k=13: partial -sin discarded, -cos decided from new sync
    for (int k = 0; k < 13; k++) tick(1'b1, k == 0, samp(2'b11, k));
    send_sym(2'b10, 1'b1, 1'b0, 1'b1);
    chk("e_sym_valid_at_T", 32'(sym_valid), 0);
    tick(1'b0, 1'b0, 8'd128);
    chk("e_sym_valid", 32'(sym_valid), 1);
    chk("e_sym_out", 32'(sym_out), 32'(2'b10));
    send_mid();
    tick(1'b0, 1'b0, 8'd128);
    tick(1'b0, 1'b0, 8'd128);

    // Reset between the two output bits: second bit dropped
    exp_sym_q.push_back(2'b11);
    exp_bit_q.push_back(1'b1);
    send_sym(2'b11, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'd128);
    chk("f_bit_valid_1", 32'(bit_valid), 1);
    @(negedge clk_slow);
    #1;
    rst = 1'b0;
    #1;
    chk("f_rst_sym_out", 32'(sym_out), 0);
    chk("f_rst_bit_valid", 32'(bit_valid), 0);
    chk("f_rst_locked", 32'(locked), 0);
    @(posedge clk_slow);
    #1;
    chk("f_bit_valid_next", 32'(bit_valid), 0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, samp(2'b01, i % 32));
    chk("f_no_lock_without_sync", 32'(locked), 0);
    send_sym(2'b01, 1'b1, 1'b0, 1'b1);
    chk("f_sym_valid_at_T", 32'(sym_valid), 0);
    tick(1'b0, 1'b0, 8'd128);
    chk("f_sym_valid", 32'(sym_valid), 1);
    chk("f_sym_out", 32'(sym_out), 32'(2'b01));
    send_mid();
    repeat (4) tick(1'b0, 1'b0, 8'd128);

    chk("sym_queue_left", 32'(exp_sym_q.size()), 0);
    chk("bit_queue_left", 32'(exp_bit_q.size()), 0);
    chk("pkt_end_count", 32'(pkt_seen), 32'(pkt_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
